// File: rtl/latch_wr_if.sv
// Handshake and latch-bank signals between a write requester and latch_wr_ctrl.
interface latch_wr_if #(
   parameter int WIDTH = 8
);
   logic             REQ;
   logic [WIDTH-1:0] DIN;
   logic             ACK;
   logic             BUSY;
   logic [WIDTH-1:0] D;
   logic             EN;
   logic             nEN;

   modport master (output REQ, DIN, input ACK, BUSY, D, EN, nEN);
   modport slave  (input REQ, DIN, output ACK, BUSY, D, EN, nEN);
endinterface

// File: rtl/latch_wr_ctrl.sv
// Write sequencer for a complementary-enable D latch bank: data is set up,
// the enable is pulsed, then data is held before completion is acknowledged.
//
// state   | meaning
// IDLE    | waiting for REQ, D holds last written word
// SETUP   | D stable, EN low, counting setup cycles
// OPEN    | EN high, latches transparent
// HOLD    | EN low again, D still held
// DONE    | one-cycle ACK pulse
module latch_wr_ctrl #(
   parameter int WIDTH = 8,
   parameter int SETUP = 1,
   parameter int PULSE = 2,
   parameter int HOLD  = 1
) (
   input  logic       CLK,
   input  logic       nRST,
   latch_wr_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_OPEN,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [3:0] SETUP_M1 = 4'(SETUP - 1);
   localparam logic [3:0] PULSE_M1 = 4'(PULSE - 1);
   localparam logic [3:0] HOLD_M1  = 4'(HOLD - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             en_q, en_d;
   logic             n_en_q, n_en_d;
   logic             ack_q, ack_d;
   logic             busy_q, busy_d;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         d_q     <= '0;
         en_q    <= 1'b0;
         n_en_q  <= 1'b1;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         en_q    <= en_d;
         n_en_q  <= n_en_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      en_d    = en_q;
      ack_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.REQ) begin
               d_d     = bus.DIN;
               state_d = S_SETUP;
               cnt_d   = SETUP_M1;
            end
         end
         S_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = S_OPEN;
               en_d    = 1'b1;
               cnt_d   = PULSE_M1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_OPEN: begin
            if (cnt_q == 4'd0) begin
               state_d = S_HOLD;
               en_d    = 1'b0;
               cnt_d   = HOLD_M1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            en_d    = 1'b0;
         end
      endcase
      // Both enables come from the same next-state value so they switch on one edge.
      n_en_d = ~en_d;
      busy_d = (state_d != S_IDLE);
   end

   assign bus.D    = d_q;
   assign bus.EN   = en_q;
   assign bus.nEN  = n_en_q;
   assign bus.ACK  = ack_q;
   assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Directed bench for latch_wr_ctrl with a write scoreboard and per-cycle output checks.
module tb_latch_wr_ctrl;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } wr_t;

   logic CLK;
   logic nRST;
   int   edge_cnt = 0;
   logic rst_q    = 1'b0;

   int n_checks = 0;
   int n_err    = 0;

   int   s_tab[2] = '{1, 3};
   int   p_tab[2] = '{2, 4};
   int   h_tab[2] = '{1, 2};
   wr_t  sb[2][$];
   logic [7:0] d_last[2];
   logic [7:0] prev_d[2];
   logic       prev_en[2];

   latch_wr_if #(.WIDTH(8)) if0 ();
   latch_wr_if #(.WIDTH(8)) if1 ();

   latch_wr_ctrl #(.WIDTH(8), .SETUP(1), .PULSE(2), .HOLD(1)) dut0 (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (if0.slave)
   );

   latch_wr_ctrl #(.WIDTH(8), .SETUP(3), .PULSE(4), .HOLD(2)) dut1 (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (if1.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      edge_cnt <= edge_cnt + 1;
      rst_q    <= nRST;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_wr(input int u, input int idx, input logic [7:0] data);
      wr_t w;
      w.idx  = idx;
      w.data = data;
      sb[u].push_back(w);
   endtask

   task automatic mon(input int u, input logic en, input logic n_en, input logic ack,
                      input logic busy, input logic [7:0] d);
      int         off;
      int         len;
      logic       en_e, ack_e, busy_e;
      logic [7:0] d_e;
      len    = s_tab[u] + p_tab[u] + h_tab[u];
      en_e   = 1'b0;
      ack_e  = 1'b0;
      busy_e = 1'b0;
      if (!rst_q) begin
         while (sb[u].size() > 0 && sb[u][0].idx < edge_cnt) void'(sb[u].pop_front());
         d_last[u] = 8'h00;
         d_e       = 8'h00;
      end else begin
         d_e = d_last[u];
         if (sb[u].size() > 0 && (edge_cnt - 1) >= sb[u][0].idx) begin
            off    = edge_cnt - 1 - sb[u][0].idx;
            d_e    = sb[u][0].data;
            busy_e = 1'b1;
            en_e   = (off >= s_tab[u]) && (off < s_tab[u] + p_tab[u]);
            ack_e  = (off == len);
            if (off == len) begin
               d_last[u] = sb[u][0].data;
               void'(sb[u].pop_front());
            end
         end
      end
      chk($sformatf("u%0d_en", u),   32'(en),   32'(en_e));
      chk($sformatf("u%0d_nen", u),  32'(n_en), 32'(!en_e));
      chk($sformatf("u%0d_ack", u),  32'(ack),  32'(ack_e));
      chk($sformatf("u%0d_busy", u), 32'(busy), 32'(busy_e));
      chk($sformatf("u%0d_d", u),    32'(d),    32'(d_e));
      if (rst_q && (en === 1'b1 || (prev_en[u] === 1'b1 && en === 1'b0)))
         chk($sformatf("u%0d_d_stable", u), 32'(d), 32'(prev_d[u]));
      prev_en[u] = en;
      prev_d[u]  = d;
   endtask

   always @(negedge CLK) begin
      mon(0, if0.EN, if0.nEN, if0.ACK, if0.BUSY, if0.D);
      mon(1, if1.EN, if1.nEN, if1.ACK, if1.BUSY, if1.D);
   end

   task automatic next_cyc(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic set_req(input int u, input logic req, input logic [7:0] din);
      if (u == 0) begin
         if0.REQ = req;
         if0.DIN = din;
      end else begin
         if1.REQ = req;
         if1.DIN = din;
      end
   endtask

   // Single-cycle request; returns in the DONE cycle of the write.
   task automatic write(input int u, input logic [7:0] data);
      next_cyc(1);
      set_req(u, 1'b1, data);
      push_wr(u, edge_cnt, data);
      next_cyc(1);
      set_req(u, 1'b0, data);
      next_cyc(s_tab[u] + p_tab[u] + h_tab[u]);
   endtask

   initial begin
      nRST    = 1'b0;
      if0.REQ = 1'b0;
      if0.DIN = 8'h00;
      if1.REQ = 1'b0;
      if1.DIN = 8'h00;
      prev_en = '{1'b0, 1'b0};
      prev_d  = '{8'h00, 8'h00};
      d_last  = '{8'h00, 8'h00};

      next_cyc(3);
      nRST = 1'b1;
      next_cyc(2);

      write(0, 8'hA5);
      next_cyc(3);

      // REQ held high: accepts every SETUP+PULSE+HOLD+2 edges
      next_cyc(1);
      if0.REQ = 1'b1;
      if0.DIN = 8'h3C;
      push_wr(0, edge_cnt,      8'h3C);
      push_wr(0, edge_cnt + 6,  8'h3C);
      push_wr(0, edge_cnt + 12, 8'h3C);
      next_cyc(13);
      if0.REQ = 1'b0;
      next_cyc(6);

      // DIN and REQ activity while busy is ignored
      next_cyc(1);
      if0.REQ = 1'b1;
      if0.DIN = 8'h11;
      push_wr(0, edge_cnt, 8'h11);
      next_cyc(1);
      if0.REQ = 1'b0;
      if0.DIN = 8'h22;
      next_cyc(1);
      if0.REQ = 1'b1;
      next_cyc(1);
      if0.REQ = 1'b0;
      next_cyc(2);
      write(0, 8'h22);
      next_cyc(2);

      // reset in the second OPEN cycle, then accept on the first released edge
      next_cyc(1);
      if0.REQ = 1'b1;
      if0.DIN = 8'hC3;
      push_wr(0, edge_cnt, 8'hC3);
      next_cyc(1);
      if0.REQ = 1'b0;
      next_cyc(2);
      nRST    = 1'b0;
      if0.REQ = 1'b1;
      if0.DIN = 8'h96;
      next_cyc(1);
      nRST = 1'b1;
      push_wr(0, edge_cnt, 8'h96);
      next_cyc(1);
      if0.REQ = 1'b0;
      next_cyc(6);

      write(1, 8'h5A);
      next_cyc(2);
      write(1, 8'hE7);
      next_cyc(4);

      chk("sb_empty", 32'(sb[0].size() + sb[1].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/latch_wr_ctrl.md
LATCH_WR_CTRL -- requirements
Module: latch_wr_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width of DIN and D.
REQ-002 Parameter SETUP, default 1: number of cycles D is stable before EN rises; legal range 1..15.
REQ-003 Parameter PULSE, default 2: number of cycles EN is high; legal range 1..15.
REQ-004 Parameter HOLD, default 1: number of cycles D is stable after EN falls; legal range 1..15.
REQ-005 Port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 Port nRST, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port REQ, input, 1 bit: write request (level); sampled only in IDLE.
REQ-008 Port DIN, input, WIDTH bits: write data; captured on the accept edge.
REQ-009 Port ACK, output, 1 bit: one-cycle completion pulse.
REQ-010 Port BUSY, output, 1 bit: high in every state except IDLE.
REQ-011 Port D, output, WIDTH bits: data to the latch bank D inputs.
REQ-012 Port EN, output, 1 bit: latch transparent enable.
REQ-013 Port nEN, output, 1 bit: complementary latch enable.

Function
REQ-014 The block SHALL drive a bank of complementary-enable D latches with a setup/pulse/hold-safe write sequence.
REQ-015 All outputs SHALL be registered; there SHALL be no combinational path from REQ or DIN to any output.
REQ-016 nEN SHALL equal the inverse of EN in every cycle, including reset; both SHALL come from the same edge.
REQ-017 The FSM SHALL have the states IDLE, SETUP, OPEN, HOLD and DONE, one-hot or encoded.
REQ-018 IDLE with REQ=1 at an edge SHALL cause: D<=DIN, state<=SETUP, counter<=SETUP-1 (accept edge).
REQ-019 IDLE with REQ=0 SHALL keep all outputs unchanged and D unchanged.
REQ-020 SETUP SHALL decrement the counter; at 0 it SHALL go to OPEN with EN<=1 and counter<=PULSE-1.
REQ-021 OPEN SHALL keep EN=1 and decrement the counter; at 0 it SHALL go to HOLD with EN<=0 and counter<=HOLD-1.
REQ-022 HOLD SHALL decrement the counter; at 0 it SHALL go to DONE with ACK<=1.
REQ-023 DONE SHALL last exactly 1 cycle, then go to IDLE with ACK<=0.
REQ-024 D SHALL NOT change from the accept edge until the DONE->IDLE edge.
REQ-025 Timing: counting cycles after the accept edge from 0, EN SHALL be high in cycles SETUP..SETUP+PULSE-1 and ACK SHALL be high in cycle SETUP+PULSE+HOLD.
REQ-026 REQ and DIN changes while BUSY=1 SHALL be ignored; there is no queueing.
REQ-027 If REQ is still high in the first IDLE cycle after DONE, the block SHALL accept a new write on that edge.
REQ-028 The minimum request-to-request period SHALL be SETUP+PULSE+HOLD+2 cycles.
REQ-029 The counter SHALL be 4 bits wide and SHALL never wrap or underflow in legal configurations.

Reset
REQ-030 nRST=0 sampled at an edge SHALL force: state=IDLE, EN=0, nEN=1, ACK=0, BUSY=0, D=0, counter=0.
REQ-031 Reset SHALL override all other behaviour, including mid-sequence; if EN was 1, it SHALL fall on the reset edge.
REQ-032 A write interrupted by reset SHALL produce no ACK.
REQ-033 In the first edge with nRST=1 and REQ=1, the block SHALL accept normally.

Verification
REQ-034 Defaults; DIN=0xA5, REQ=1 for one cycle at edge k -> D=0xA5 from k+1; EN=1, nEN=0 in cycles k+2..k+3; ACK=1 in cycle k+5 only; BUSY=1 in cycles k+1..k+5.
REQ-035 REQ held high continuously with defaults -> accepts at edges 0, 6, 12; ACK pulses in cycles 5, 11, 17; EN is never high in consecutive write windows without a gap.
REQ-036 DIN changes 0x11->0x22 while BUSY=1 -> D stays 0x11 until DONE; the next accept captures the current DIN.
REQ-037 nRST=0 in the second OPEN cycle -> next cycle EN=0, nEN=1, D=0x00, BUSY=0; no ACK follows.
REQ-038 SETUP=3, PULSE=4, HOLD=2 -> EN high in cycles 3..6 after accept, ACK in cycle 9; nEN==~EN checked on every cycle.
REQ-039 The bench SHALL check, throughout all scenarios, that D never changes while EN=1 or in the cycle EN falls.
